part_reg_fifo: RTL and testbench

Parametrised successor to the octal 74S374-style register: a WIDTH-bit, DEPTH-entry synchronous register stack with first-word-fall-through output, full/empty/count status, sticky overflow/underflow flags and the same active-low tristate output enable. It sits between a producing datapath and a shared tristate bus. It replaces chains of single-rank octal latches where the producer and consumer must be decoupled by more than one word.

---
 rtl/part_reg_fifo.sv | 83 ++++++++
 tb/tb_part_reg_fifo.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/part_reg_fifo.sv
// Parametrised first-word-fall-through register stack with count/full/empty status,
// sticky overflow/underflow flags and an active-low tristate output enable.
module part_reg_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned CW = $clog2(DEPTH + 1),
  localparam int unsigned PW = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [WIDTH-1:0] D,
  input  logic             WR,
  input  logic             RD,
  input  logic             OENB_N,
  output logic [WIDTH-1:0] Q,
  output logic             EMPTY,
  output logic             FULL,
  output logic [CW-1:0]    COUNT,
  output logic             OVF,
  output logic             UNF
);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [PW-1:0] LAST_P  = PW'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wp, rp, wp_nxt, rp_nxt;
  logic [CW-1:0]    count;
  logic             ovf, unf;
  logic             rd_ok, wr_ok;
  logic [WIDTH-1:0] head;

  // A full stack still accepts a write when the same edge pops a word.
  always_comb begin
    rd_ok  = RD && (count != '0);
    wr_ok  = WR && ((count < DEPTH_C) || rd_ok);
    wp_nxt = (wp == LAST_P) ? '0 : wp + 1'b1;
    rp_nxt = (rp == LAST_P) ? '0 : rp + 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (!RESET && wr_ok)
      mem[wp] <= D;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end else begin
      if (wr_ok)
        wp <= wp_nxt;
      if (rd_ok)
        rp <= rp_nxt;
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (WR && !wr_ok)
        ovf <= 1'b1;
      if (RD && !rd_ok)
        unf <= 1'b1;
    end
  end

  always_comb begin
    head = '0;
    if (count != '0)
      head = mem[rp];
  end

  assign Q     = OENB_N ? {WIDTH{1'bz}} : head;
  assign EMPTY = (count == '0);
  assign FULL  = (count == DEPTH_C);
  assign COUNT = count;
  assign OVF   = ovf;
  assign UNF   = unf;

endmodule

// File: tb/tb_part_reg_fifo.sv
// Bench for part_reg_fifo: vector table on a DEPTH=4 instance plus hand sequences
// for tristate release and DEPTH=3 streaming with pointer wrap.
module tb_part_reg_fifo;

  logic       clk = 1'b0;
  logic       rst, wr, rd, oe_n;
  logic [7:0] d;

  // Pulled-up nets: a released bus reads all-ones instead of a driven value.
  tri1  [7:0] q4, q3;
  logic       empty4, full4, ovf4, unf4;
  logic       empty3, full3, ovf3, unf3;
  logic [2:0] count4;
  logic [1:0] count3;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  part_reg_fifo #(.WIDTH(8), .DEPTH(4)) dut4 (
    .CLK(clk), .RESET(rst), .D(d), .WR(wr), .RD(rd), .OENB_N(oe_n),
    .Q(q4), .EMPTY(empty4), .FULL(full4), .COUNT(count4), .OVF(ovf4), .UNF(unf4)
  );

  part_reg_fifo #(.WIDTH(8), .DEPTH(3)) dut3 (
    .CLK(clk), .RESET(rst), .D(d), .WR(wr), .RD(rd), .OENB_N(oe_n),
    .Q(q3), .EMPTY(empty3), .FULL(full3), .COUNT(count3), .OVF(ovf3), .UNF(unf3)
  );

  typedef struct {
    logic       rst, wr, rd, oe_n;
    logic [7:0] d;
    logic [7:0] q;
    logic [2:0] cnt;
    logic       ovf, unf;
  } vec_t;

  vec_t vecs[28];

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d] got=%0h expected=%0h", name, idx, act, exp);
    end
  endtask

  task automatic run_vec(input int i);
    @(negedge clk);
    rst = vecs[i].rst; wr = vecs[i].wr; rd = vecs[i].rd;
    oe_n = vecs[i].oe_n; d = vecs[i].d;
    @(posedge clk);
    #1;
    chk("q", i, {24'h0, q4}, {24'h0, vecs[i].q});
    chk("count", i, {29'h0, count4}, {29'h0, vecs[i].cnt});
    chk("empty", i, {31'h0, empty4}, {31'h0, vecs[i].cnt == 3'd0});
    chk("full", i, {31'h0, full4}, {31'h0, vecs[i].cnt == 3'd4});
    chk("ovf", i, {31'h0, ovf4}, {31'h0, vecs[i].ovf});
    chk("unf", i, {31'h0, unf4}, {31'h0, vecs[i].unf});
  endtask

  initial begin
    rst = 1'b1; wr = 1'b0; rd = 1'b0; oe_n = 1'b0; d = 8'h00;

    //          rst wr rd oe   d      q     cnt ovf unf
    vecs[0]  = '{1, 0, 0, 0, 8'h00, 8'h00, 3'd0, 0, 0};
    vecs[1]  = '{0, 1, 0, 0, 8'h11, 8'h11, 3'd1, 0, 0};
    vecs[2]  = '{0, 1, 0, 0, 8'h22, 8'h11, 3'd2, 0, 0};
    vecs[3]  = '{0, 1, 0, 0, 8'h33, 8'h11, 3'd3, 0, 0};
    vecs[4]  = '{0, 1, 0, 0, 8'h44, 8'h11, 3'd4, 0, 0};
    vecs[5]  = '{0, 1, 0, 0, 8'h55, 8'h11, 3'd4, 1, 0};
    vecs[6]  = '{0, 0, 1, 0, 8'h00, 8'h22, 3'd3, 1, 0};
    vecs[7]  = '{0, 0, 1, 0, 8'h00, 8'h33, 3'd2, 1, 0};
    vecs[8]  = '{0, 0, 1, 0, 8'h00, 8'h44, 3'd1, 1, 0};
    vecs[9]  = '{0, 0, 1, 0, 8'h00, 8'h00, 3'd0, 1, 0};
    vecs[10] = '{0, 1, 1, 0, 8'hA5, 8'hA5, 3'd1, 1, 1};
    vecs[11] = '{0, 0, 1, 0, 8'h00, 8'h00, 3'd0, 1, 1};
    vecs[12] = '{0, 0, 1, 0, 8'h00, 8'h00, 3'd0, 1, 1};
    vecs[13] = '{0, 1, 0, 1, 8'h66, 8'hFF, 3'd1, 1, 1};
    vecs[14] = '{0, 1, 0, 1, 8'h77, 8'hFF, 3'd2, 1, 1};
    vecs[15] = '{0, 0, 1, 1, 8'h00, 8'hFF, 3'd1, 1, 1};
    vecs[16] = '{1, 0, 0, 0, 8'h00, 8'h00, 3'd0, 0, 0};
    vecs[17] = '{0, 1, 0, 0, 8'h88, 8'h88, 3'd1, 0, 0};
    vecs[18] = '{0, 1, 0, 0, 8'h99, 8'h88, 3'd2, 0, 0};
    vecs[19] = '{0, 1, 0, 0, 8'hAA, 8'h88, 3'd3, 0, 0};
    vecs[20] = '{0, 1, 0, 0, 8'hBB, 8'h88, 3'd4, 0, 0};
    vecs[21] = '{0, 1, 1, 0, 8'hCC, 8'h99, 3'd4, 0, 0};
    vecs[22] = '{0, 0, 1, 0, 8'h00, 8'hAA, 3'd3, 0, 0};
    vecs[23] = '{0, 1, 0, 0, 8'hDD, 8'hAA, 3'd4, 0, 0};
    vecs[24] = '{0, 1, 0, 0, 8'hEE, 8'hAA, 3'd4, 1, 0};
    vecs[25] = '{0, 0, 1, 0, 8'h00, 8'hBB, 3'd3, 1, 0};
    vecs[26] = '{1, 1, 0, 0, 8'hF0, 8'h00, 3'd0, 0, 0};
    vecs[27] = '{0, 0, 0, 0, 8'h00, 8'h00, 3'd0, 0, 0};

    for (int i = 0; i < 16; i++)
      run_vec(i);

    // Re-enable the output mid-cycle: head (0x77) must appear without a clock edge.
    @(negedge clk);
    wr = 1'b0; rd = 1'b0;
    #1 oe_n = 1'b0;
    #1;
    chk("oe_q", 0, {24'h0, q4}, 32'h77);
    chk("oe_count", 0, {29'h0, count4}, 32'd1);
    oe_n = 1'b1;
    #1;
    chk("oe_z", 0, {24'h0, q4}, 32'hFF);
    oe_n = 1'b0;

    for (int i = 16; i < 28; i++)
      run_vec(i);

    // DEPTH=3 streaming: one preload, then simultaneous push/pop across pointer wrap.
    @(negedge clk);
    rst = 1'b1; wr = 1'b0; rd = 1'b0; oe_n = 1'b0; d = 8'h00;
    @(negedge clk);
    rst = 1'b0; wr = 1'b1; d = 8'h00;
    @(posedge clk);
    #1;
    chk("s_pre_q", 0, {24'h0, q3}, 32'h00);
    chk("s_pre_count", 0, {30'h0, count3}, 32'd1);
    chk("s_pre_empty", 0, {31'h0, empty3}, 32'd0);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      wr = 1'b1; rd = 1'b1; d = 8'(k);
      #1;
      chk("s_before_q", k, {24'h0, q3}, k - 1);
      @(posedge clk);
      #1;
      chk("s_q", k, {24'h0, q3}, k);
      chk("s_count", k, {30'h0, count3}, 32'd1);
      chk("s_flags", k, {30'h0, ovf3, unf3}, 32'd0);
      chk("s_full", k, {31'h0, full3}, 32'd0);
    end
    @(negedge clk);
    wr = 1'b0; rd = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
